instr_fetch_mem: RTL and testbench

Instruction memory for the fetch stage. PC lookups use a valid/ready request/response handshake.
- Configurable fetch group of 1..N consecutive instructions per request, from word-interleaved banks.
- Response FIFO so a stalled decoder never loses data.
- Flush for branch redirects, error flag for bad PCs, byte-enabled load port.
- Sits between the PC generator and decode, replacing the single-word stall-gated memory.

---
 rtl/instr_fetch_pkg.sv | 29 ++
 rtl/instr_mem_bank.sv | 37 +++
 rtl/instr_fetch_mem.sv | 193 +++++++++++++++++++
 tb/tb_instr_fetch_mem.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared types and helpers for the grouped instruction fetch memory.
package instr_fetch_pkg;

  // Default configuration of the fetch memory.
  localparam int IF_WIDTH       = 32;
  localparam int IF_DEPTH       = 1024;
  localparam int IF_FETCH_WORDS = 2;

  // Data bit pattern returned with an error response (replicated across the group).
  localparam logic ERR_DATA = 1'b0;

  // Response entry for the default configuration: PC, rotated group data, error flag.
  typedef struct packed {
    logic [IF_WIDTH-1:0]                pc;
    logic [IF_FETCH_WORDS*IF_WIDTH-1:0] data;
    logic                               err;
  } fetch_rsp_t;

  // Word index of a byte-addressed PC (drops the byte offset).
  function automatic int unsigned word_index(input logic [31:0] pc);
    return {2'b00, pc[31:2]};
  endfunction

  // Bank that holds word w when words are interleaved across f banks.
  function automatic int unsigned bank_of(input int unsigned w, input int unsigned f);
    return w % f;
  endfunction

endpackage

// File: rtl/instr_mem_bank.sv
// One interleaved bank: synchronous registered read, byte-enabled write,
// read-before-write when both ports hit the same row in one cycle.
module instr_mem_bank #(
  parameter int width_p = 32,
  parameter int depth_p = 512,
  localparam int addr_w_lp = (depth_p > 1) ? $clog2(depth_p) : 1
) (
  input  logic                 clk,
  input  logic                 rd_en,
  input  logic [addr_w_lp-1:0] rd_addr,
  output logic [width_p-1:0]   rd_data,
  input  logic                 wr_en,
  input  logic [addr_w_lp-1:0] wr_addr,
  input  logic [width_p-1:0]   wr_data,
  input  logic [width_p/8-1:0] wr_be
);

  logic [width_p-1:0] mem [depth_p];
  logic [width_p-1:0] rd_data_reg;

  // Read samples the old contents; byte lanes are written independently.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data_reg <= mem[rd_addr];
    end
    if (wr_en) begin
      for (int b = 0; b < width_p / 8; b++) begin
        if (wr_be[b]) begin
          mem[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
        end
      end
    end
  end

  assign rd_data = rd_data_reg;

endmodule

// File: rtl/instr_fetch_mem.sv
// Grouped instruction fetch memory: word-interleaved banks, one-cycle read
// latency, in-order response FIFO with flush, error flagging and a load port.
module instr_fetch_mem
  import instr_fetch_pkg::*;
#(
  parameter int    width_p       = IF_WIDTH,
  parameter int    depth_p       = IF_DEPTH,
  parameter int    fetch_words_p = IF_FETCH_WORDS,
  parameter int    fifo_depth_p  = 2,
  parameter string init_file_p   = ""
) (
  input  logic                             clk_i,
  input  logic                             reset_ni,
  input  logic                             req_valid_i,
  output logic                             req_ready_o,
  input  logic [width_p-1:0]               req_pc_i,
  input  logic                             flush_i,
  output logic                             rsp_valid_o,
  input  logic                             rsp_ready_i,
  output logic [width_p-1:0]               rsp_pc_o,
  output logic [fetch_words_p*width_p-1:0] rsp_data_o,
  output logic                             rsp_err_o,
  input  logic                             load_en_i,
  input  logic [$clog2(depth_p*4)-1:0]     load_addr_i,
  input  logic [width_p-1:0]               load_data_i,
  input  logic [width_p/8-1:0]             load_be_i
);

  localparam int rows_lp    = depth_p / fetch_words_p;
  localparam int row_w_lp   = (rows_lp > 1) ? $clog2(rows_lp) : 1;
  localparam int addr_w_lp  = $clog2(depth_p * 4);
  localparam int rot_w_lp   = (fetch_words_p > 1) ? $clog2(fetch_words_p) : 1;
  localparam int ptr_w_lp   = $clog2(fifo_depth_p);
  localparam int occ_w_lp   = $clog2(fifo_depth_p + 1);
  localparam int group_w_lp = fetch_words_p * width_p;
  localparam int unsigned nbank_lp = 32'(fetch_words_p);

  typedef struct packed {
    logic [width_p-1:0]    pc;
    logic [group_w_lp-1:0] data;
    logic                  err;
  } rsp_entry_t;

  // Request decode
  logic                accept;
  logic                deq;
  logic                req_err;
  logic                pc_high;
  logic                rd_en;
  int unsigned         req_w;
  int unsigned         load_w;
  logic [row_w_lp-1:0] load_row;

  // Bank interface
  logic [row_w_lp-1:0]      rd_row  [fetch_words_p];
  logic [width_p-1:0]       bank_rd [fetch_words_p];
  logic [fetch_words_p-1:0] bank_wr_en;

  // In-flight read (bank output registers hold its data)
  logic                inflight_reg;
  logic [width_p-1:0]  inflight_pc_reg;
  logic                inflight_err_reg;
  logic [rot_w_lp-1:0] inflight_rot_reg;
  logic [group_w_lp-1:0] rot_data;
  rsp_entry_t          inflight_entry;

  // Response FIFO
  rsp_entry_t          fifo_mem [fifo_depth_p];
  logic [ptr_w_lp-1:0] wr_ptr_reg;
  logic [ptr_w_lp-1:0] rd_ptr_reg;
  logic [occ_w_lp-1:0] occ_reg;
  logic                fifo_push;
  logic                fifo_pop;
  rsp_entry_t          head_entry;

  // Any PC bit beyond the byte-address range makes the request out of range.
  if (width_p > addr_w_lp) begin : g_pc_high
    assign pc_high = |req_pc_i[width_p-1:addr_w_lp];
  end else begin : g_pc_no_high
    assign pc_high = 1'b0;
  end

  // Handshake, error classification and FIFO movement for this cycle.
  always_comb begin
    req_w   = word_index(32'(req_pc_i[addr_w_lp-1:0]));
    load_w  = word_index(32'(load_addr_i));
    load_row = row_w_lp'(load_w / nbank_lp);
    req_err = (req_pc_i[1:0] != 2'b00) || pc_high ||
              ((req_w + nbank_lp) > 32'(depth_p));
    deq     = rsp_valid_o && rsp_ready_i;
    // Space counts the queued entries plus the read already in the banks.
    req_ready_o = flush_i ||
                  ((32'(occ_reg) + 32'(inflight_reg) - 32'(deq)) < 32'(fifo_depth_p));
    accept  = req_valid_i && req_ready_o;
    rd_en   = accept && !req_err;
    // The in-flight entry goes straight out when it is consumed with an empty FIFO.
    fifo_push = !flush_i && inflight_reg && !(deq && (occ_reg == '0));
    fifo_pop  = !flush_i && deq && (occ_reg != '0);
  end

  // Per-bank row selection and load steering.
  for (genvar gi = 0; gi < fetch_words_p; gi++) begin : g_bank
    // Lane k of the group lives in bank (w+k)%F, so this bank serves lane (gi-w)%F.
    assign rd_row[gi] = row_w_lp'((req_w +
                          ((32'(gi) + nbank_lp - bank_of(req_w, nbank_lp)) % nbank_lp))
                          / nbank_lp);
    assign bank_wr_en[gi] = load_en_i && (bank_of(load_w, nbank_lp) == 32'(gi));

    instr_mem_bank #(
      .width_p (width_p),
      .depth_p (rows_lp)
    ) u_bank (
      .clk     (clk_i),
      .rd_en   (rd_en),
      .rd_addr (rd_row[gi]),
      .rd_data (bank_rd[gi]),
      .wr_en   (bank_wr_en[gi]),
      .wr_addr (load_row),
      .wr_data (load_data_i),
      .wr_be   (load_be_i)
    );
  end

  // Rotate bank outputs so the word at the request PC lands in lane 0.
  always_comb begin
    rot_data = '0;
    for (int k = 0; k < fetch_words_p; k++) begin
      for (int b = 0; b < fetch_words_p; b++) begin
        if (((32'(inflight_rot_reg) + 32'(k)) % nbank_lp) == 32'(b)) begin
          rot_data[k*width_p +: width_p] = bank_rd[b];
        end
      end
    end
  end

  // Build the in-flight entry and pick the response head.
  always_comb begin
    inflight_entry.pc   = inflight_pc_reg;
    inflight_entry.err  = inflight_err_reg;
    inflight_entry.data = inflight_err_reg ? {group_w_lp{ERR_DATA}} : rot_data;
    head_entry  = (occ_reg != '0) ? fifo_mem[rd_ptr_reg] : inflight_entry;
    rsp_valid_o = (occ_reg != '0) || inflight_reg;
    rsp_pc_o    = rsp_valid_o ? head_entry.pc   : '0;
    rsp_data_o  = rsp_valid_o ? head_entry.data : '0;
    rsp_err_o   = rsp_valid_o ? head_entry.err  : 1'b0;
  end

  // Track the read issued this cycle; flush keeps only a same-cycle accept.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      inflight_reg     <= 1'b0;
      inflight_pc_reg  <= '0;
      inflight_err_reg <= 1'b0;
      inflight_rot_reg <= '0;
    end else begin
      inflight_reg <= accept;
      if (accept) begin
        inflight_pc_reg  <= req_pc_i;
        inflight_err_reg <= req_err;
        inflight_rot_reg <= rot_w_lp'(bank_of(req_w, nbank_lp));
      end
    end
  end

  // FIFO pointers and occupancy; flush empties the queue.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      occ_reg    <= '0;
    end else if (flush_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      occ_reg    <= '0;
    end else begin
      if (fifo_push) begin
        wr_ptr_reg <= (wr_ptr_reg == ptr_w_lp'(fifo_depth_p - 1)) ? '0 : wr_ptr_reg + 1'b1;
      end
      if (fifo_pop) begin
        rd_ptr_reg <= (rd_ptr_reg == ptr_w_lp'(fifo_depth_p - 1)) ? '0 : rd_ptr_reg + 1'b1;
      end
      occ_reg <= occ_reg + occ_w_lp'(fifo_push) - occ_w_lp'(fifo_pop);
    end
  end

  // FIFO storage captures the in-flight entry once its bank data is valid.
  always_ff @(posedge clk_i) begin
    if (fifo_push) begin
      fifo_mem[wr_ptr_reg] <= inflight_entry;
    end
  end

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Directed bench for instr_fetch_mem with a queue-based reference model.
module tb_instr_fetch_mem;

  localparam int W  = 32;
  localparam int D  = 1024;
  localparam int F  = 2;
  localparam int FD = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [W-1:0]  req_pc;
  logic          flush;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [W-1:0]  rsp_pc;
  logic [F*W-1:0] rsp_data;
  logic          rsp_err;
  logic          load_en;
  logic [11:0]   load_addr;
  logic [W-1:0]  load_data;
  logic [3:0]    load_be;

  instr_fetch_mem #(
    .width_p(W), .depth_p(D), .fetch_words_p(F), .fifo_depth_p(FD), .init_file_p("")
  ) dut (
    .clk_i(clk), .reset_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_pc_i(req_pc),
    .flush_i(flush),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_pc_o(rsp_pc), .rsp_data_o(rsp_data), .rsp_err_o(rsp_err),
    .load_en_i(load_en), .load_addr_i(load_addr), .load_data_i(load_data), .load_be_i(load_be)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [63:0] data;
    logic        err;
  } rsp_t;

  int n_checks = 0;
  int n_fail   = 0;
  int n_acc    = 0;
  int cyc      = 0;

  logic [31:0] mm [D];     // model memory
  rsp_t        q [$];      // model: responses owed (including the one in flight)
  rsp_t        got [$];    // DUT responses actually consumed
  int          got_cyc [$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // What a fetch of pc must return, straight from the memory image.
  function automatic rsp_t expect_fetch(input logic [31:0] pc);
    rsp_t r;
    int unsigned w;
    w = pc >> 2;
    r.pc  = pc;
    r.err = (pc[1:0] != 2'b00) || (w + F > D);
    r.data = r.err ? 64'h0 : {mm[w+1], mm[w]};
    return r;
  endfunction

  function automatic bit model_ready();
    int owed;
    owed = q.size() - ((q.size() > 0 && rsp_ready) ? 1 : 0);
    return flush || (owed < FD);
  endfunction

  // Reference model advances on each edge using the inputs of the cycle just ended.
  always @(posedge clk or negedge rst_n) begin
    rsp_t n;
    bit   acc;
    if (!rst_n) begin
      q.delete();
    end else begin
      cyc++;
      acc = req_valid && model_ready();
      if (acc) n = expect_fetch(req_pc);
      if (flush) q.delete();
      else if (q.size() > 0 && rsp_ready) void'(q.pop_front());
      if (acc) begin
        q.push_back(n);
        n_acc++;
      end
      if (load_en) begin
        for (int b = 0; b < 4; b++)
          if (load_be[b]) mm[load_addr >> 2][b*8 +: 8] = load_data[b*8 +: 8];
      end
    end
  end

  // Per-cycle comparison of DUT outputs against the model, mid-cycle.
  always @(negedge clk) begin
    rsp_t r;
    if (!rst_n) begin
      check("reset_rsp_valid", rsp_valid, 1'b0);
      check("reset_req_ready", req_ready, 1'b1);
      check("reset_rsp_fields", {rsp_pc, rsp_data, rsp_err}, '0);
    end else begin
      check("req_ready", req_ready, model_ready());
      check("rsp_valid", rsp_valid, q.size() > 0);
      if (q.size() > 0) begin
        check("rsp_pc", rsp_pc, q[0].pc);
        check("rsp_data", rsp_data, q[0].data);
        check("rsp_err", rsp_err, q[0].err);
      end
      if (rsp_valid && rsp_ready && !flush) begin
        r.pc = rsp_pc; r.data = rsp_data; r.err = rsp_err;
        got.push_back(r);
        got_cyc.push_back(cyc);
        $display("RSP cycle=%0d pc=%08h data=%016h err=%0d", cyc, rsp_pc, rsp_data, rsp_err);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (q.size() != 0 && n < 30) begin
      tick();
      n++;
    end
    check("drain_done", q.size(), 0);
  endtask

  task automatic check_rsp(input string name, input int idx, input logic [31:0] pc,
                           input logic [63:0] d, input logic e);
    check({name, "_present"}, got.size() > idx, 1'b1);
    if (got.size() > idx) begin
      check({name, "_pc"}, got[idx].pc, pc);
      check({name, "_data"}, got[idx].data, d);
      check({name, "_err"}, got[idx].err, e);
    end
  endtask

  task automatic load_word(input int w, input logic [31:0] d);
    load_en = 1'b1; load_addr = 12'(w * 4); load_data = d; load_be = 4'hF;
    tick();
    load_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int acc0;
    int ready_low;
    logic [31:0] pcs [4];

    rst_n = 1'b0; req_valid = 1'b0; req_pc = '0; flush = 1'b0; rsp_ready = 1'b0;
    load_en = 1'b0; load_addr = '0; load_data = '0; load_be = '0;
    repeat (3) tick();
    check("reset_valid_lit", rsp_valid, 1'b0);
    check("reset_ready_lit", req_ready, 1'b1);
    rst_n = 1'b1;
    tick();

    // Preload the memory image through the load port.
    for (int i = 0; i < 16; i++) load_word(i, 32'h100 + 32'(i));
    load_word(1022, 32'hAAAA0000);
    load_word(1023, 32'hAAAA0001);

    // Back-to-back aligned groups with an always-ready consumer.
    rsp_ready = 1'b1; base = got.size(); acc0 = n_acc; ready_low = 0;
    pcs[0] = 32'h0; pcs[1] = 32'h8; pcs[2] = 32'h10;
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1; req_pc = pcs[i];
      if (!req_ready) ready_low++;
      tick();
    end
    req_valid = 1'b0;
    wait_drain();
    check("b2b_accepts", n_acc - acc0, 3);
    check("b2b_ready_low", ready_low, 0);
    check_rsp("b2b0", base, 32'h0, 64'h00000101_00000100, 1'b0);
    check_rsp("b2b2", base + 2, 32'h10, 64'h00000105_00000104, 1'b0);
    if (got.size() > base + 2) begin
      check("b2b_consecutive1", got_cyc[base+1] - got_cyc[base], 1);
      check("b2b_consecutive2", got_cyc[base+2] - got_cyc[base+1], 1);
    end

    // Group that straddles a bank row.
    base = got.size();
    req_valid = 1'b1; req_pc = 32'h4; tick();
    req_valid = 1'b0;
    wait_drain();
    check_rsp("straddle", base, 32'h4, 64'h00000102_00000101, 1'b0);

    // Consumer stalled while the producer requests every cycle.
    rsp_ready = 1'b0; base = got.size(); acc0 = n_acc;
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1; req_pc = 32'h20 + 32'(8 * i);
      tick();
    end
    check("stall_accepts", n_acc - acc0, 2);
    check("stall_ready_low", req_ready, 1'b0);
    req_valid = 1'b0; rsp_ready = 1'b1;
    wait_drain();
    check_rsp("stall0", base, 32'h20, 64'h00000109_00000108, 1'b0);
    check_rsp("stall1", base + 1, 32'h28, 64'h0000010B_0000010A, 1'b0);

    // Flush with queued and in-flight responses plus a new-path request.
    rsp_ready = 1'b0; base = got.size();
    req_valid = 1'b1; req_pc = 32'h0; tick();
    req_pc = 32'h8; tick();
    req_valid = 1'b0; tick();
    flush = 1'b1; req_valid = 1'b1; req_pc = 32'h20; tick();
    flush = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
    wait_drain();
    check("flush_count", got.size() - base, 1);
    check_rsp("flush_new", base, 32'h20, 64'h00000109_00000108, 1'b0);

    // Misaligned, overrunning and out-of-range PCs, then the last legal group.
    base = got.size(); rsp_ready = 1'b1;
    pcs[0] = 32'h2; pcs[1] = 32'hFFC; pcs[2] = 32'h1000; pcs[3] = 32'hFF8;
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1; req_pc = pcs[i]; tick();
    end
    req_valid = 1'b0;
    wait_drain();
    check_rsp("err_misalign", base, 32'h2, 64'h0, 1'b1);
    check_rsp("err_overrun", base + 1, 32'hFFC, 64'h0, 1'b1);
    check_rsp("err_range", base + 2, 32'h1000, 64'h0, 1'b1);
    check_rsp("last_group", base + 3, 32'hFF8, 64'hAAAA0001_AAAA0000, 1'b0);

    // Byte-enabled load colliding with a fetch of the same word.
    base = got.size();
    req_valid = 1'b1; req_pc = 32'h8;
    load_en = 1'b1; load_addr = 12'h8; load_data = 32'hDEADBEEF; load_be = 4'b0011;
    tick();
    load_en = 1'b0;
    tick();
    req_valid = 1'b0;
    wait_drain();
    check_rsp("load_old", base, 32'h8, 64'h00000103_00000102, 1'b0);
    check_rsp("load_new", base + 1, 32'h8, 64'h00000103_0000BEEF, 1'b0);

    // Reset in the middle of a pending response; memory must survive.
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_pc = 32'h0; tick();
    req_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 check("midreset_valid", rsp_valid, 1'b0);
    check("midreset_ready", req_ready, 1'b1);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    base = got.size(); rsp_ready = 1'b1;
    req_valid = 1'b1; req_pc = 32'h8; tick();
    req_valid = 1'b0;
    wait_drain();
    check_rsp("after_reset", base, 32'h8, 64'h00000103_0000BEEF, 1'b0);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
